tmds_channel_rx: RTL and testbench

- Receive-side counterpart of the DVI transmit path: recovers one TMDS channel from 10-bit parallel words supplied by an external deserializer of arbitrary bit phase.
- Performs word alignment by control-token search, then decodes each symbol into pixel data (8-bit) or control (2-bit) plus DE.
- Three instances, one per channel, sit behind the deserializer in the capture path, clocked by the recovered pixel clock.

---
 rtl/tmds_pkg.sv | 39 +++
 rtl/tmds_decode_word.sv | 27 ++
 rtl/tmds_channel_rx.sv | 139 +++++++++++++
 tb/tb_tmds_channel_rx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared constants, types and control-token lookup for the TMDS channel receiver.
package tmds_pkg;

  localparam int unsigned SYM_W  = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CTRL_W = 2;
  localparam int unsigned OFS_W  = 4;
  localparam int unsigned WIN_W  = 2 * SYM_W;

  localparam logic [SYM_W-1:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_TOK_11 = 10'b1010101011;

  typedef enum logic {
    SEARCH,
    LOCKED
  } state_e;

  typedef struct packed {
    logic              hit;
    logic [CTRL_W-1:0] val;
  } ctrl_lut_t;

  function automatic ctrl_lut_t ctrl_lookup(input logic [SYM_W-1:0] q);
    ctrl_lut_t r;
    r.hit = 1'b1;
    r.val = '0;
    case (q)
      CTRL_TOK_00: r.val = 2'b00;
      CTRL_TOK_01: r.val = 2'b01;
      CTRL_TOK_10: r.val = 2'b10;
      CTRL_TOK_11: r.val = 2'b11;
      default:     r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tmds_decode_word.sv
// Combinational TMDS symbol decoder: control-token detect plus 10b->8b data decode.
module tmds_decode_word
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0]  q_i,
  output logic              is_ctrl_c,
  output logic [CTRL_W-1:0] ctrl_c,
  output logic [DATA_W-1:0] data_c
);

  ctrl_lut_t         lut;
  logic [DATA_W-1:0] qp;

  always_comb begin
    lut       = ctrl_lookup(q_i);
    is_ctrl_c = lut.hit;
    ctrl_c    = lut.val;
    // undo the optional inversion, then the XOR/XNOR transition chain
    qp        = q_i[9] ? ~q_i[7:0] : q_i[7:0];
    data_c    = '0;
    data_c[0] = qp[0];
    for (int i = 1; i < int'(DATA_W); i++) begin
      data_c[i] = q_i[8] ? (qp[i] ^ qp[i-1]) : ~(qp[i] ^ qp[i-1]);
    end
  end

endmodule

// File: rtl/tmds_channel_rx.sv
// One TMDS receive channel: word alignment by control-token search, then symbol decode.
module tmds_channel_rx
  import tmds_pkg::*;
#(
  parameter int unsigned CTRL_RUN   = 16,
  parameter int unsigned SEARCH_WIN = 2048,
  parameter int unsigned MAX_GAP    = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SYM_W-1:0]  sym_in,
  output logic              de,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl,
  output logic              locked,
  output logic [OFS_W-1:0]  offset
);

  localparam int unsigned RUN_W = $clog2(CTRL_RUN) + 1;
  localparam int unsigned WCN_W = $clog2(SEARCH_WIN) + 1;
  localparam int unsigned GAP_W = $clog2(MAX_GAP) + 1;

  logic [SYM_W-1:0]  cur_q, prev_q;
  logic [OFS_W-1:0]  offset_q, offset_d;
  state_e            state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [WCN_W-1:0]  win_q, win_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              locked_q, locked_d;
  logic              de_q, de_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  logic [WIN_W-1:0]  win_c;
  logic [SYM_W-1:0]  sel_c;
  logic              is_ctrl_c;
  logic [CTRL_W-1:0] dec_ctrl_c;
  logic [DATA_W-1:0] dec_data_c;

  // Older word sits in the low half since bit 0 is the earliest serial bit.
  always_comb begin
    win_c = {cur_q, prev_q};
    sel_c = prev_q;
    for (int i = 0; i < int'(SYM_W); i++) begin
      if (offset_q == OFS_W'(i)) sel_c = win_c[i +: SYM_W];
    end
  end

  tmds_decode_word u_dec (
    .q_i       (sel_c),
    .is_ctrl_c (is_ctrl_c),
    .ctrl_c    (dec_ctrl_c),
    .data_c    (dec_data_c)
  );

  // Alignment FSM next-state and output-register next values.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    run_d    = run_q;
    win_d    = win_q;
    gap_d    = gap_q;
    locked_d = locked_q;
    de_d     = 1'b0;
    data_d   = '0;
    ctrl_d   = ctrl_q;

    case (state_q)
      SEARCH: begin
        win_d = (win_q == {WCN_W{1'b1}}) ? win_q : WCN_W'(win_q + 1'b1);
        if (is_ctrl_c) run_d = (run_q == {RUN_W{1'b1}}) ? run_q : RUN_W'(run_q + 1'b1);
        else           run_d = '0;
        // a lock on the same cycle as window expiry keeps the current offset
        if (run_d >= RUN_W'(CTRL_RUN)) begin
          state_d  = LOCKED;
          locked_d = 1'b1;
          gap_d    = '0;
        end else if (win_q >= WCN_W'(SEARCH_WIN - 1)) begin
          offset_d = (offset_q == OFS_W'(SYM_W - 1)) ? '0 : OFS_W'(offset_q + 1'b1);
          win_d    = '0;
          run_d    = '0;
        end
      end
      LOCKED: begin
        if (is_ctrl_c) gap_d = '0;
        else           gap_d = (gap_q == {GAP_W{1'b1}}) ? gap_q : GAP_W'(gap_q + 1'b1);
        if (gap_d >= GAP_W'(MAX_GAP)) begin
          state_d  = SEARCH;
          locked_d = 1'b0;
          win_d    = '0;
          run_d    = '0;
        end
      end
      default: state_d = SEARCH;
    endcase

    if (is_ctrl_c) begin
      ctrl_d = dec_ctrl_c;
    end else if (locked_q) begin
      de_d   = 1'b1;
      data_d = dec_data_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_q    <= '0;
      prev_q   <= '0;
      offset_q <= '0;
      state_q  <= SEARCH;
      run_q    <= '0;
      win_q    <= '0;
      gap_q    <= '0;
      locked_q <= 1'b0;
      de_q     <= 1'b0;
      data_q   <= '0;
      ctrl_q   <= '0;
    end else begin
      cur_q    <= sym_in;
      prev_q   <= cur_q;
      offset_q <= offset_d;
      state_q  <= state_d;
      run_q    <= run_d;
      win_q    <= win_d;
      gap_q    <= gap_d;
      locked_q <= locked_d;
      de_q     <= de_d;
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign de     = de_q;
  assign data   = data_q;
  assign ctrl   = ctrl_q;
  assign locked = locked_q;
  assign offset = offset_q;

endmodule

// File: tb/tb_tmds_channel_rx.sv
// Directed bench for tmds_channel_rx with shortened search window and gap limit.
module tb_tmds_channel_rx;

  localparam int unsigned CTRL_RUN   = 16;
  localparam int unsigned SEARCH_WIN = 64;
  localparam int unsigned MAX_GAP    = 32;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] sym_in;
  logic       de;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       locked;
  logic [3:0] offset;

  int total = 0;
  int bad   = 0;

  tmds_channel_rx #(
    .CTRL_RUN   (CTRL_RUN),
    .SEARCH_WIN (SEARCH_WIN),
    .MAX_GAP    (MAX_GAP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sym_in (sym_in),
    .de     (de),
    .data   (data),
    .ctrl   (ctrl),
    .locked (locked),
    .offset (offset)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // present one word, then land 1 time unit after the edge that captures it
  task automatic step(input logic [9:0] w);
    sym_in = w;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_de"},     32'(de),     32'd0);
    check_val({tag, "_data"},   32'(data),   32'd0);
    check_val({tag, "_ctrl"},   32'(ctrl),   32'd0);
    check_val({tag, "_locked"}, 32'(locked), 32'd0);
    check_val({tag, "_offset"}, 32'(offset), 32'd0);
  endtask

  // from a fresh reset release: lock after edge 18 of a TOK00 stream
  task automatic aligned_lock(input string tag);
    for (int i = 1; i <= 17; i++) step(TOK00);
    check_val({tag, "_prelock"}, 32'(locked), 32'd0);
    step(TOK00);
    check_val({tag, "_lock"},   32'(locked), 32'd1);
    check_val({tag, "_offset"}, 32'(offset), 32'd0);
    check_val({tag, "_ctrl"},   32'(ctrl),   32'd0);
  endtask

  initial begin
    logic [9:0] tok;
    logic [9:0] rot;
    int         ch [4];
    int         lock_n;
    int         n;
    logic [3:0] last_ofs;

    rst    = 1'b0;
    sym_in = '0;

    for (int i = 0; i < 5; i++) begin
      step(10'($urandom));
      check_idle("rst_hold");
    end
    rst = 1'b1;
    step(TOK00);
    check_idle("rst_rel");
    for (int i = 2; i <= 17; i++) step(TOK00);
    check_val("al_prelock", 32'(locked), 32'd0);
    step(TOK00);
    check_val("al_lock",   32'(locked), 32'd1);
    check_val("al_offset", 32'(offset), 32'd0);
    check_val("al_ctrl",   32'(ctrl),   32'd0);

    // data decode, three-edge latency
    step(10'h100);
    check_val("dd_lat0", 32'(de), 32'd0);
    step(10'h2FF);
    check_val("dd_lat1", 32'(de), 32'd0);
    step(TOK01);
    check_val("dd100_de",   32'(de),   32'd1);
    check_val("dd100_data", 32'(data), 32'h00);
    step(TOK00);
    check_val("dd2ff_de",   32'(de),   32'd1);
    check_val("dd2ff_data", 32'(data), 32'hFE);
    step(TOK00);
    check_val("ddtok_de",   32'(de),   32'd0);
    check_val("ddtok_data", 32'(data), 32'h00);
    check_val("ddtok_ctrl", 32'(ctrl), 32'h1);
    step(TOK00);
    check_val("dd_ctrl00", 32'(ctrl),   32'h0);
    check_val("dd_locked", 32'(locked), 32'd1);

    // loss of lock after MAX_GAP data words
    for (int i = 0; i < 32; i++) step(10'h100);
    step(10'h100);
    check_val("gap_still", 32'(locked), 32'd1);
    step(10'h100);
    check_val("gap_drop",   32'(locked), 32'd0);
    check_val("gap_de_lag", 32'(de),     32'd1);
    step(10'h100);
    check_val("gap_de",     32'(de),     32'd0);
    check_val("gap_data",   32'(data),   32'h00);
    check_val("gap_offset", 32'(offset), 32'd0);
    for (int i = 0; i < 17; i++) step(TOK00);
    check_val("relock_pre", 32'(locked), 32'd0);
    step(TOK00);
    check_val("relock",        32'(locked), 32'd1);
    check_val("relock_offset", 32'(offset), 32'd0);

    // asynchronous reset while data flows
    step(10'h2FF);
    step(10'h2FF);
    step(10'h2FF);
    check_val("mid_de",   32'(de),   32'd1);
    check_val("mid_data", 32'(data), 32'hFE);
    #2 rst = 1'b0;
    #1;
    check_idle("mid_rst");
    step(10'h2FF);
    check_idle("mid_rst_hold");
    rst = 1'b1;
    aligned_lock("mid_relock");

    // misaligned stream needing offset 3
    rst = 1'b0;
    step(10'h000);
    rst = 1'b1;
    tok = TOK10;
    for (int j = 0; j < 10; j++) rot[j] = tok[(j + 7) % 10];
    for (int k = 0; k < 4; k++) ch[k] = 0;
    lock_n   = 0;
    last_ofs = 4'd0;
    n        = 0;
    while (lock_n == 0 && n < 400) begin
      step(rot);
      n++;
      if (offset != last_ofs) begin
        check_val("mis_step", 32'(offset), 32'(last_ofs + 4'd1));
        if (offset < 4'd4) ch[offset] = n;
        last_ofs = offset;
      end
      if (locked) lock_n = n;
    end
    check_val("mis_timeout", 32'(lock_n != 0), 32'd1);
    check_val("mis_ch1",     32'(ch[1]),         32'd64);
    check_val("mis_ch2",     32'(ch[2] - ch[1]), 32'd64);
    check_val("mis_ch3",     32'(ch[3] - ch[2]), 32'd64);
    check_val("mis_lockdly", 32'(lock_n - ch[3]), 32'd16);
    check_val("mis_offset",  32'(offset), 32'd3);
    check_val("mis_ctrl",    32'(ctrl),   32'h2);
    for (int i = 0; i < 5; i++) step(rot);
    check_val("mis_hold_ofs", 32'(offset), 32'd3);
    check_val("mis_hold_lck", 32'(locked), 32'd1);
    check_val("mis_hold_de",  32'(de),     32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
